// File: rtl/cordic_sqrt_arb.sv
// Round-robin arbiter that shares one square-root engine among NREQ requesters.
// Each job is latched at grant, issued once, and answered with a result or a timeout error.
module cordic_sqrt_arb #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [32*NREQ-1:0]   req_din,
   input  logic [4:0]           cfg_iterations,
   output logic [NREQ-1:0]      ack,
   output logic [15:0]          rsp_dout,
   output logic                 rsp_err,
   output logic                 arb_busy,
   output logic                 eng_start,
   output logic [31:0]          eng_din,
   output logic [4:0]           eng_iterations,
   input  logic [15:0]          eng_dout,
   input  logic                 eng_ready,
   input  logic                 eng_busy
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int PW = IW + 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [31:0]     din_q, din_d;
   logic [4:0]      iter_q, iter_d;
   logic [15:0]     res_q, res_d;
   logic            err_q, err_d;
   logic            skip_q, skip_d;

   logic [NREQ-1:0] elig;
   logic            found;
   logic [IW-1:0]   win;
   logic [31:0]     win_din;
   logic [PW-1:0]   pos;

   // The requester served last is masked for one IDLE cycle while its req falls.
   always_comb begin
      elig = req;
      if (skip_q) elig[idx_q] = 1'b0;
      found = 1'b0;
      win   = '0;
      pos   = '0;
      for (int k = 0; k < NREQ; k++) begin
         pos = {1'b0, ptr_q} + PW'(k);
         if (pos >= PW'(NREQ)) pos = pos - PW'(NREQ);
         if (!found && elig[pos[IW-1:0]]) begin
            found = 1'b1;
            win   = pos[IW-1:0];
         end
      end
      win_din = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == IW'(i)) win_din = req_din[32*i +: 32];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         din_q   <= '0;
         iter_q  <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
         skip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         din_q   <= din_d;
         iter_q  <= iter_d;
         res_q   <= res_d;
         err_q   <= err_d;
         skip_q  <= skip_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      din_d   = din_q;
      iter_d  = iter_q;
      res_d   = res_q;
      err_d   = err_q;
      skip_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (found && !eng_busy) begin
               state_d = ISSUE;
               idx_d   = win;
               din_d   = win_din;
               iter_d  = cfg_iterations;
               ptr_d   = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // Abort when the incremented count would reach TIMEOUT-1, so ack lands TIMEOUT cycles after start.
            if (eng_ready) begin
               res_d   = eng_dout;
               err_d   = 1'b0;
               state_d = DELIVER;
            end else if (cnt_q == CW'(TIMEOUT - 2)) begin
               res_d   = '0;
               err_d   = 1'b1;
               state_d = DELIVER;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DELIVER: begin
            skip_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ack = '0;
      if (state_q == DELIVER) ack[idx_q] = 1'b1;
      eng_start      = (state_q == ISSUE);
      arb_busy       = (state_q != IDLE);
      rsp_dout       = res_q;
      rsp_err        = err_q;
      eng_din        = din_q;
      eng_iterations = iter_q;
   end

endmodule

// File: tb/tb_cordic_sqrt_arb.sv
// Randomized and directed bench for cordic_sqrt_arb with a behavioural engine and
// a round-robin service-order model working on pending-request sets.
module tb_cordic_sqrt_arb;
   localparam int NREQ    = 4;
   localparam int TIMEOUT = 64;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req;
   logic [32*NREQ-1:0]  req_din;
   logic [4:0]          cfg_iterations;
   logic [NREQ-1:0]     ack;
   logic [15:0]         rsp_dout;
   logic                rsp_err;
   logic                arb_busy;
   logic                eng_start;
   logic [31:0]         eng_din;
   logic [4:0]          eng_iterations;
   logic [15:0]         eng_dout;
   logic                eng_ready;
   logic                eng_busy;
   logic                eng_bsy_int;
   logic                ext_busy;

   assign eng_busy = eng_bsy_int | ext_busy;

   cordic_sqrt_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req(req), .req_din(req_din),
      .cfg_iterations(cfg_iterations), .ack(ack), .rsp_dout(rsp_dout),
      .rsp_err(rsp_err), .arb_busy(arb_busy), .eng_start(eng_start),
      .eng_din(eng_din), .eng_iterations(eng_iterations), .eng_dout(eng_dout),
      .eng_ready(eng_ready), .eng_busy(eng_busy)
   );

   always #5 clk = ~clk;

   int          cyc = 0;
   int          n_chk = 0;
   int          n_err = 0;
   int          n_starts = 0;
   int          st_cyc = -1;
   int          rdy_cyc = -1;
   logic [31:0] st_din;
   logic [4:0]  st_it;
   int          eng_delay;
   bit          eng_mute;
   logic [31:0] eng_op;
   int          m_ptr;
   logic [31:0] ops_r [NREQ];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] isqrt(input logic [31:0] x);
      longint r, t;
      r = 0;
      for (int b = 15; b >= 0; b--) begin
         t = r + (longint'(1) << b);
         if (t * t <= longint'(x)) r = t;
      end
      return 32'(r);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   task automatic set_din();
      for (int i = 0; i < NREQ; i++) req_din[32*i +: 32] = ops_r[i];
   endtask

   // Engine: replies isqrt(operand) eng_delay cycles after it sees eng_start.
   initial begin
      eng_ready   = 1'b0;
      eng_dout    = '0;
      eng_bsy_int = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         eng_ready = 1'b0;
         if (eng_start === 1'b1 && !eng_mute) begin
            eng_op      = eng_din;
            eng_bsy_int = 1'b1;
            repeat (eng_delay) begin
               @(posedge clk);
               #1;
            end
            eng_ready   = 1'b1;
            eng_dout    = 16'(isqrt(eng_op));
            eng_bsy_int = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (eng_start === 1'b1) begin
            st_cyc = cyc;
            st_din = eng_din;
            st_it  = eng_iterations;
            n_starts++;
         end
         if (eng_ready === 1'b1) rdy_cyc = cyc;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic wait_ack(input int budget, output logic [NREQ-1:0] a, output logic [15:0] d,
                           output logic e, output int c, output bit ok);
      ok = 1'b0; a = '0; d = '0; e = 1'b0; c = 0;
      for (int n = 0; n < budget && !ok; n++) begin
         tick();
         if (ack !== '0) begin
            ok = 1'b1; a = ack; d = rsp_dout; e = rsp_err; c = cyc;
         end
      end
   endtask

   task automatic wait_start(input int budget, input int base, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < budget && !ok; n++) begin
         tick();
         if (n_starts > base) ok = 1'b1;
      end
   endtask

   // Raise all requesters in mask at once; expect them served in cyclic order from m_ptr.
   task automatic run_round(input logic [NREQ-1:0] mask, input int dly, input logic [4:0] it);
      logic [NREQ-1:0] pend, a;
      logic [15:0]     d;
      logic            e;
      int              c, exp_i, j;
      bit              ok;
      eng_delay = dly;
      cfg_iterations = it;
      set_din();
      req  = mask;
      pend = mask;
      while (pend != '0) begin
         exp_i = -1;
         for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (exp_i < 0 && pend[j]) exp_i = j;
         end
         m_ptr = (exp_i + 1) % NREQ;
         wait_ack(200, a, d, e, c, ok);
         check("rr_ack_seen", 32'(ok), 32'(1));
         if (!ok) begin
            req = '0;
            break;
         end
         check("rr_ack", 32'(a), 32'(1) << exp_i);
         check("rr_dout", 32'(d), isqrt(ops_r[exp_i]));
         check("rr_err", 32'(e), 32'(0));
         check("rr_din_at_start", st_din, ops_r[exp_i]);
         check("rr_iter", 32'(st_it), 32'(it));
         check("rr_ack_latency", 32'(c), 32'(rdy_cyc + 1));
         pend[exp_i] = 1'b0;
         req[exp_i]  = 1'b0;
      end
   endtask

   initial begin
      logic [NREQ-1:0] a;
      logic [15:0]     d;
      logic            e;
      int              c, c1, g, f, nst, bad_ack, bad_busy;
      bit              ok;
      logic [NREQ-1:0] rmask;

      rst = 1'b1; req = '0; req_din = '0; cfg_iterations = '0;
      ext_busy = 1'b0; eng_mute = 1'b0; eng_delay = 5; m_ptr = 0;
      for (int i = 0; i < NREQ; i++) ops_r[i] = '0;
      repeat (3) tick();
      check("rst_ack", 32'(ack), 32'(0));
      check("rst_busy", 32'(arb_busy), 32'(0));
      check("rst_start", 32'(eng_start), 32'(0));
      check("rst_dout", 32'(rsp_dout), 32'(0));
      check("rst_err", 32'(rsp_err), 32'(0));
      check("rst_eng_din", eng_din, 32'(0));
      check("rst_eng_iter", 32'(eng_iterations), 32'(0));
      rst = 1'b0;
      tick();

      // Single request, then the same requester kept high is re-served after the skip cycle.
      ops_r[0] = 9; set_din(); cfg_iterations = 5'd16; eng_delay = 5;
      nst = n_starts; g = cyc; req = 4'b0001;
      wait_ack(100, a, d, e, c, ok);
      c1 = c;
      check("single_seen", 32'(ok), 32'(1));
      check("single_ack", 32'(a), 32'(1));
      check("single_dout", 32'(d), 32'(3));
      check("single_err", 32'(e), 32'(0));
      check("single_start_lat", 32'(st_cyc), 32'(g + 1));
      check("single_ack_lat", 32'(c), 32'(rdy_cyc + 1));
      check("single_start_once", 32'(n_starts - nst), 32'(1));
      check("single_din", st_din, 32'(9));
      check("single_iter", 32'(st_it), 32'(16));
      wait_ack(100, a, d, e, c, ok);
      check("regrant_seen", 32'(ok), 32'(1));
      check("regrant_start", 32'(st_cyc), 32'(c1 + 3));
      check("regrant_ack", 32'(a), 32'(1));
      check("regrant_dout", 32'(d), 32'(3));
      req = '0;
      tick();
      check("ack_low", 32'(ack), 32'(0));
      check("hold_dout", 32'(rsp_dout), 32'(3));

      rst = 1'b1;
      tick();
      check("rst2_dout", 32'(rsp_dout), 32'(0));
      check("rst2_eng_din", eng_din, 32'(0));
      check("rst2_eng_iter", 32'(eng_iterations), 32'(0));
      rst = 1'b0;
      m_ptr = 0;
      tick();

      // Round robin with all four held.
      ops_r[0] = 4; ops_r[1] = 9; ops_r[2] = 16; ops_r[3] = 25;
      run_round(4'b1111, 3, 5'd7);
      run_round(4'b1111, 4, 5'd7);

      // Fairness after the pointer moves past requester 0.
      ops_r[0] = 36;
      run_round(4'b0001, 2, 5'd3);
      ops_r[0] = 49; ops_r[2] = 64;
      run_round(4'b0101, 2, 5'd3);

      // Timeout with a silent engine.
      eng_mute = 1'b1;
      ops_r[1] = 100; set_din();
      req = 4'b0010;
      wait_ack(200, a, d, e, c, ok);
      check("tmo_seen", 32'(ok), 32'(1));
      check("tmo_ack", 32'(a), 32'(2));
      check("tmo_err", 32'(e), 32'(1));
      check("tmo_dout", 32'(d), 32'(0));
      check("tmo_latency", 32'(c - st_cyc), 32'(TIMEOUT));
      req = '0; m_ptr = 2; eng_mute = 1'b0;
      tick();
      ops_r[2] = 81;
      run_round(4'b0100, 4, 5'd9);

      // Reset in the middle of WAIT abandons the job; the late engine reply is ignored.
      eng_delay = 10;
      ops_r[1] = 144; set_din();
      nst = n_starts;
      req = 4'b0010;
      wait_start(20, nst, ok);
      check("rstjob_started", 32'(ok), 32'(1));
      repeat (3) tick();
      rst = 1'b1; req = '0;
      tick();
      rst = 1'b0;
      check("rstjob_busy", 32'(arb_busy), 32'(0));
      check("rstjob_ack", 32'(ack), 32'(0));
      bad_ack = 0; bad_busy = 0;
      repeat (15) begin
         tick();
         if (ack !== '0) bad_ack++;
         if (arb_busy !== 1'b0) bad_busy++;
      end
      check("rstjob_no_ack", 32'(bad_ack), 32'(0));
      check("rstjob_stay_idle", 32'(bad_busy), 32'(0));
      m_ptr = 0;
      ops_r[0] = 1; ops_r[3] = 1000000;
      run_round(4'b1001, 3, 5'd2);

      // Engine busy defers the grant; early drop still gets the latched operand.
      eng_delay = 4;
      ext_busy = 1'b1;
      ops_r[1] = 16; set_din();
      nst = n_starts;
      req = 4'b0010;
      repeat (5) tick();
      check("busy_blocks", 32'(n_starts - nst), 32'(0));
      check("busy_idle", 32'(arb_busy), 32'(0));
      ext_busy = 1'b0;
      f = cyc;
      wait_start(10, nst, ok);
      check("busy_release_seen", 32'(ok), 32'(1));
      check("busy_release_lat", 32'(st_cyc), 32'(f + 1));
      req = '0;
      ops_r[1] = 0; set_din();
      wait_ack(100, a, d, e, c, ok);
      check("drop_seen", 32'(ok), 32'(1));
      check("drop_ack", 32'(a), 32'(2));
      check("drop_dout", 32'(d), 32'(4));
      check("drop_err", 32'(e), 32'(0));
      check("drop_din_held", eng_din, 32'(16));
      m_ptr = 2;
      tick();

      for (int r = 0; r < 20; r++) begin
         rmask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         for (int i = 0; i < NREQ; i++) ops_r[i] = $urandom;
         run_round(rmask, int'($urandom_range(1, 8)), 5'($urandom_range(0, 31)));
      end

      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/cordic_sqrt_arb.md
CORDIC_SQRT_ARB -- requirements
Module: cordic_sqrt_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter TIMEOUT, default 64, maximum cycles to wait for engine ready before abort.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  NREQ  per-requester request; held high until matching ack.
REQ-006 req_din  input  32*NREQ  operand for requester i in bits [32i+31:32i].
REQ-007 cfg_iterations  input  5  iteration count forwarded to the engine, sampled at grant.
REQ-008 ack  output  NREQ  one-cycle pulse to the requester whose result is on rsp_dout.
REQ-009 rsp_dout  output  16  square-root result, valid only while ack is non-zero.
REQ-010 rsp_err  output  1  asserted with ack when the job timed out; rsp_dout is then 0.
REQ-011 arb_busy  output  1  high in every state except IDLE.
REQ-012 eng_start  output  1  one-cycle start pulse to the sqrt engine.
REQ-013 eng_din  output  32  operand to the engine, held stable from eng_start until result capture.
REQ-014 eng_iterations  output  5  iteration count to the engine, held stable alongside eng_din.
REQ-015 eng_dout  input  16  engine result.
REQ-016 eng_ready  input  1  engine result-valid pulse.
REQ-017 eng_busy  input  1  engine busy flag.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, DELIVER.
REQ-019 IDLE: if any req bit is high and eng_busy is low, grant one requester, latch its req_din and cfg_iterations, store its index, and go to ISSUE; otherwise stay in IDLE.
REQ-020 Arbitration is round-robin: search from pointer ptr upward, modulo NREQ; the first high req wins; ptr becomes winner+1 (mod NREQ) on grant.
REQ-021 ISSUE: assert eng_start for exactly this one cycle, clear the timeout counter, and go to WAIT.
REQ-022 WAIT: when eng_ready is high, capture eng_dout, clear the error flag, and go to DELIVER.
REQ-023 WAIT: increment the counter each cycle; if the counter reaches TIMEOUT-1 without eng_ready, set the error flag, zero the captured result, and go to DELIVER.
REQ-024 DELIVER: pulse ack at the stored index for one cycle, drive rsp_dout and rsp_err from the captured values, and return to IDLE.
REQ-025 Latency: grant at edge t gives eng_start in cycle t+1; eng_ready at cycle r gives ack in cycle r+1.
REQ-026 A requester that drops req after grant still receives its ack; the latched operand is used.
REQ-027 In the IDLE cycle after DELIVER, the just-served requester's req is ignored, because ack-to-req deassertion takes one cycle; it may be granted again from the following cycle.
REQ-028 eng_ready seen outside WAIT is ignored.
REQ-029 eng_din and eng_iterations change only on grant.
REQ-030 ack is zero in every state except DELIVER.
REQ-031 rsp_dout and rsp_err hold their last value when ack is low.

Reset
REQ-032 While rst is high at an edge: state becomes IDLE, ptr becomes 0, and the counter and error flag are cleared.
REQ-033 While rst is high at an edge: ack, eng_start, and arb_busy become 0, and rsp_dout, rsp_err, eng_din, and eng_iterations become 0.
REQ-034 Reset asserted mid-job (ISSUE, WAIT, or DELIVER) abandons the job with no ack.
REQ-035 A later eng_ready belonging to the abandoned job is ignored per REQ-028.

Verification
REQ-036 Single request: req=0001, din0=9, engine model replies 3 after 5 cycles -> eng_start one cycle after grant, ack=0001 with rsp_dout=3 and rsp_err=0 one cycle after eng_ready.
REQ-037 Round-robin: req=1111 held with din 4,9,16,25 -> acks in order 0,1,2,3 with results 2,3,4,5; then order 0,1,2,3 again.
REQ-038 Fairness after pointer move: serve req0, then raise req0 and req2 together -> req2 is served before req0.
REQ-039 Timeout: engine never asserts ready, TIMEOUT=64 -> ack 64 cycles after eng_start with rsp_err=1 and rsp_dout=0; the next request completes normally.
REQ-040 Reset mid-WAIT: rst high for one cycle while in WAIT, then eng_ready pulses -> no ack, arb_busy=0, ptr=0.
REQ-041 Early drop: requester 1 drops req one cycle after grant, din1=16 -> ack=0010 with rsp_dout=4; eng_busy high in IDLE delays the grant until eng_busy falls.
